// File: rtl/keypad_4x4_scanner_if.sv
// rtl/keypad_4x4_scanner_if.sv - keypad matrix wiring and decoded key outputs
// master: scanner side; slave: keypad/consumer side.
interface keypad_4x4_scanner_if;
   logic [3:0] i_row_n;
   logic [3:0] o_col_n;
   logic [3:0] o_key;
   logic       o_key_valid;
   logic       o_key_held;
   logic       o_multi;

   modport master (
      input  i_row_n,
      output o_col_n,
      output o_key,
      output o_key_valid,
      output o_key_held,
      output o_multi
   );

   modport slave (
      output i_row_n,
      input  o_col_n,
      input  o_key,
      input  o_key_valid,
      input  o_key_held,
      input  o_multi
   );
endinterface

// File: rtl/keypad_4x4_scanner.sv
// rtl/keypad_4x4_scanner.sv - 4x4 matrix keypad scanner with full-snapshot debounce
// Internal snapshot bit index is row*4+col, so a single set bit index is directly the key code.
module keypad_4x4_scanner #(
   parameter int SCAN_DIV = 100000,
   parameter int DB_SCANS = 20
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   keypad_4x4_scanner_if.master  io_kp
);
   localparam int CW = $clog2(SCAN_DIV);
   localparam int SW = $clog2(DB_SCANS + 1);
   localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
   localparam logic [SW-1:0] STAB_MAX  = SW'(DB_SCANS);

   typedef enum logic {S_IDLE, S_HELD} state_t;

   logic [CW-1:0] r_slot;
   logic [1:0]    r_col;
   logic [3:0]    r_col_n;
   logic [3:0]    r_row_meta;
   logic [3:0]    r_row_sync;
   logic [15:0]   r_snap;
   logic [15:0]   r_prev;
   logic [SW-1:0] r_stab;
   logic [15:0]   r_deb;
   logic          r_multi;
   state_t        r_state;
   logic [3:0]    r_key;
   logic          r_key_valid;
   logic          r_key_held;

   logic          w_slot_last;
   logic          w_scan_done;
   logic [3:0]    w_rows;
   logic [15:0]   w_snap_next;
   logic [SW-1:0] w_stab_next;
   logic [4:0]    w_deb_cnt;
   logic [3:0]    w_deb_idx;
   state_t        w_state_next;
   logic [3:0]    w_key_next;
   logic          w_valid_next;
   logic          w_held_next;

   assign w_slot_last = (r_slot == SLOT_LAST);
   assign w_scan_done = w_slot_last && (r_col == 2'd3);
   assign w_rows      = ~r_row_sync;

   // Merge the current column's rows into the snapshot so a completed scan sees all 16 keys.
   always_comb begin
      w_snap_next = r_snap;
      for (int r = 0; r < 4; r++) begin
         w_snap_next[r*4 + int'(r_col)] = w_rows[r];
      end
   end

   always_comb begin
      w_stab_next = SW'(1);
      if (w_snap_next == r_prev) begin
         w_stab_next = (r_stab == STAB_MAX) ? r_stab : r_stab + SW'(1);
      end
   end

   always_comb begin
      w_deb_cnt = 5'd0;
      w_deb_idx = 4'd0;
      for (int i = 0; i < 16; i++) begin
         w_deb_cnt = w_deb_cnt + {4'd0, r_deb[i]};
         if (r_deb[i]) begin
            w_deb_idx = 4'(i);
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_row_meta <= 4'hF;
         r_row_sync <= 4'hF;
      end else begin
         r_row_meta <= io_kp.i_row_n;
         r_row_sync <= r_row_meta;
      end
   end

   // Column drive is registered alongside the index so it changes right after the wrap.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_slot  <= '0;
         r_col   <= 2'd0;
         r_col_n <= 4'b1110;
      end else if (w_slot_last) begin
         r_slot  <= '0;
         r_col   <= r_col + 2'd1;
         r_col_n <= ~(4'b0001 << (r_col + 2'd1));
      end else begin
         r_slot  <= r_slot + CW'(1);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_snap <= 16'd0;
         r_prev <= 16'd0;
         r_stab <= '0;
         r_deb  <= 16'd0;
      end else if (w_slot_last) begin
         r_snap <= w_snap_next;
         if (w_scan_done) begin
            r_prev <= w_snap_next;
            r_stab <= w_stab_next;
            if (w_stab_next == STAB_MAX) begin
               r_deb <= w_snap_next;
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_multi <= 1'b0;
      end else begin
         r_multi <= (w_deb_cnt >= 5'd2);
      end
   end

   // A key is accepted only from S_IDLE, which needs a full release after the previous one.
   always_comb begin
      w_state_next = r_state;
      w_key_next   = r_key;
      w_valid_next = 1'b0;
      w_held_next  = r_key_held;
      case (r_state)
         S_IDLE: begin
            if (w_deb_cnt == 5'd1) begin
               w_state_next = S_HELD;
               w_key_next   = w_deb_idx;
               w_valid_next = 1'b1;
               w_held_next  = 1'b1;
            end
         end
         S_HELD: begin
            if (r_deb == 16'd0) begin
               w_state_next = S_IDLE;
               w_held_next  = 1'b0;
            end
         end
         default: begin
            w_state_next = S_IDLE;
            w_held_next  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_key       <= 4'd0;
         r_key_valid <= 1'b0;
         r_key_held  <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_key       <= w_key_next;
         r_key_valid <= w_valid_next;
         r_key_held  <= w_held_next;
      end
   end

   assign io_kp.o_col_n     = r_col_n;
   assign io_kp.o_key       = r_key;
   assign io_kp.o_key_valid = r_key_valid;
   assign io_kp.o_key_held  = r_key_held;
   assign io_kp.o_multi     = r_multi;
endmodule

// File: tb/tb_keypad_4x4_scanner.sv
// tb/tb_keypad_4x4_scanner.sv - directed bench with keypad matrix model and key scoreboard
module tb_keypad_4x4_scanner;
   localparam int SCAN = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] mask = 16'd0;
   logic [3:0]  w_row_n;
   logic [3:0]  exp_q[$];
   int total = 0;
   int bad = 0;
   int cyc = 0;
   int n_valid = 0;
   int last_valid_cyc = -1;

   keypad_4x4_scanner_if kp();

   keypad_4x4_scanner #(.SCAN_DIV(4), .DB_SCANS(3)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .io_kp (kp)
   );

   always #5 clk = ~clk;

   // Pressed key at row r, col c pulls row r low while column c is driven low.
   always_comb begin
      w_row_n = 4'hF;
      for (int r = 0; r < 4; r++) begin
         w_row_n[r] = ~|(mask[r*4 +: 4] & ~kp.o_col_n);
      end
   end
   assign kp.i_row_n = w_row_n;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      if (kp.o_key_valid === 1'b1) begin
         n_valid++;
         last_valid_cyc = cyc;
         chk("valid_expected", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) chk("valid_key", 32'(kp.o_key), 32'(exp_q.pop_front()));
      end
   endtask

   task automatic run_scans(input int n);
      repeat (n * SCAN) tick();
   endtask

   task automatic sync_scan();
      int n;
      n = 0;
      while (kp.o_col_n !== 4'b0111 && n < 80) begin tick(); n++; end
      while (kp.o_col_n !== 4'b1110 && n < 80) begin tick(); n++; end
      chk("scan_sync", 32'(n < 80), 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_col_n"}, 32'(kp.o_col_n), 32'hE);
      chk({tag, "_key"}, 32'(kp.o_key), 0);
      chk({tag, "_valid"}, 32'(kp.o_key_valid), 0);
      chk({tag, "_held"}, 32'(kp.o_key_held), 0);
      chk({tag, "_multi"}, 32'(kp.o_multi), 0);
   endtask

   initial begin
      int p;
      int v0;
      logic [3:0] exp_col;

      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;

      for (int i = 0; i < 32; i++) begin
         exp_col = ~(4'b0001 << ((i / 4) % 4));
         chk("col_seq", 32'(kp.o_col_n), 32'(exp_col));
         tick();
      end
      chk("idle_key", 32'(kp.o_key), 0);
      chk("idle_held", 32'(kp.o_key_held), 0);
      chk("idle_multi", 32'(kp.o_multi), 0);
      chk("idle_pulses", n_valid, 0);

      // Key 9 (row 2, col 1) held for 5 scans.
      sync_scan();
      mask = 16'h0200;
      exp_q.push_back(4'd9);
      p = cyc;
      v0 = n_valid;
      run_scans(5);
      chk("k9_pulses", n_valid - v0, 1);
      chk("k9_latency", 32'(last_valid_cyc - p <= 3 * SCAN + 2), 1);
      chk("k9_key", 32'(kp.o_key), 9);
      chk("k9_held", 32'(kp.o_key_held), 1);
      chk("k9_q_empty", exp_q.size(), 0);
      mask = 16'd0;
      run_scans(4);
      chk("k9_rel_held", 32'(kp.o_key_held), 0);
      chk("k9_rel_key", 32'(kp.o_key), 9);

      // Bounce: 2 on, 1 off, 2 on, then a stable hold.
      v0 = n_valid;
      mask = 16'h0200;
      run_scans(2);
      mask = 16'd0;
      run_scans(1);
      mask = 16'h0200;
      run_scans(2);
      chk("bounce_no_pulse", n_valid - v0, 0);
      exp_q.push_back(4'd9);
      run_scans(3);
      chk("bounce_pulses", n_valid - v0, 1);
      chk("bounce_key", 32'(kp.o_key), 9);
      mask = 16'd0;
      run_scans(4);

      // Rollover: key 0 then add key 15.
      mask = 16'h0001;
      exp_q.push_back(4'd0);
      v0 = n_valid;
      run_scans(4);
      chk("k0_key", 32'(kp.o_key), 0);
      chk("k0_held", 32'(kp.o_key_held), 1);
      mask = 16'h8001;
      run_scans(4);
      chk("roll_multi", 32'(kp.o_multi), 1);
      chk("roll_held", 32'(kp.o_key_held), 1);
      chk("roll_pulses", n_valid - v0, 1);
      mask = 16'd0;
      run_scans(4);
      chk("roll_rel_held", 32'(kp.o_key_held), 0);
      chk("roll_rel_multi", 32'(kp.o_multi), 0);
      mask = 16'h8000;
      exp_q.push_back(4'd15);
      run_scans(4);
      chk("k15_key", 32'(kp.o_key), 15);
      chk("k15_held", 32'(kp.o_key_held), 1);
      mask = 16'd0;
      run_scans(4);

      // Two keys from idle.
      v0 = n_valid;
      mask = 16'h1008;
      run_scans(5);
      chk("dual_multi", 32'(kp.o_multi), 1);
      chk("dual_held", 32'(kp.o_key_held), 0);
      chk("dual_pulses", n_valid - v0, 0);
      chk("dual_key", 32'(kp.o_key), 15);
      mask = 16'd0;
      run_scans(4);
      chk("dual_rel_multi", 32'(kp.o_multi), 0);

      // Asynchronous reset while key 5 is held.
      sync_scan();
      mask = 16'h0020;
      exp_q.push_back(4'd5);
      run_scans(4);
      chk("k5_key", 32'(kp.o_key), 5);
      chk("k5_held", 32'(kp.o_key_held), 1);
      #2 rst = 1'b1;
      #1 check_reset_outputs("async_rst");
      tick();
      rst = 1'b0;
      v0 = n_valid;
      exp_q.push_back(4'd5);
      run_scans(5);
      chk("k5_again_pulses", n_valid - v0, 1);
      chk("k5_again_key", 32'(kp.o_key), 5);
      chk("k5_again_held", 32'(kp.o_key_held), 1);
      chk("final_q_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
